// File: rtl/ftf23_pkg.sv
// Shared constants and types for the 23-wire FTF receive decoder.
// Holds the Fibonacci weight table and the partial-sum helper used by the decoder pipeline.
package ftf23_pkg;

  localparam int TSV_W      = 23;
  localparam int FBLEN23    = 17;
  localparam int CODE_LIMIT = 75025;

  // The weighted sum is split at this bit so each S2 adder stays short.
  localparam int LO_LAST    = 11;

  typedef logic [TSV_W-1:0]   codeword_t;
  typedef logic [FBLEN23-1:0] data_t;
  typedef data_t              fib_table_t [TSV_W];

  // Weight of codeword bit k is Fib(k+2).
  localparam fib_table_t FIB_W = '{
    17'd1,     17'd2,     17'd3,     17'd5,     17'd8,
    17'd13,    17'd21,    17'd34,    17'd55,    17'd89,
    17'd144,   17'd233,   17'd377,   17'd610,   17'd987,
    17'd1597,  17'd2584,  17'd4181,  17'd6765,  17'd10946,
    17'd17711, 17'd28657, 17'd46368
  };

  // Sum of the weights of the set bits of cw within [first, last].
  // The full-word sum is at most 121391, so 17 bits never overflow.
  function automatic data_t fib_sum(input codeword_t cw, input int first, input int last);
    data_t s;
    s = '0;
    for (int k = 0; k < TSV_W; k++) begin
      if (k >= first && k <= last && cw[k]) begin
        s = s + FIB_W[k];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/ftf_pattern_check_23.sv
// Combinational forbidden-pattern detector for a 23-bit FTF codeword.
// Odd positions may not fall 1->0 into the next bit; even positions may not rise 0->1.
module ftf_pattern_check_23
  import ftf23_pkg::*;
(
  input  codeword_t i_code,
  output logic      o_forbidden
);

  logic [TSV_W-2:0] w_viol;

  for (genvar gi = 0; gi < TSV_W-1; gi++) begin : g_pair
    if (gi % 2 == 1) begin : g_odd
      assign w_viol[gi] = i_code[gi] & ~i_code[gi+1];
    end else begin : g_even
      assign w_viol[gi] = ~i_code[gi] & i_code[gi+1];
    end
  end

  assign o_forbidden = |w_viol;

endmodule

// File: rtl/ftf_rx_decoder_23.sv
// Three-stage receive decoder for the 23-wire FTF TSV link.
// S1 captures the codeword, S2 holds two partial Fibonacci sums (and the pattern
// flag), S3 is the output register with the final sum and flags.
// Optional checking (pattern/range flags and error counter) is built only when
// FTF_RX_CHECK_EN is defined; otherwise the flag outputs and counter read 0.
module ftf_rx_decoder_23
  import ftf23_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [TSV_W-1:0]   tsv_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FBLEN23-1:0] dataout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_pattern,
  output logic               err_range,
  output logic [CNT_W-1:0]   err_count,
  input  logic               err_clear
);

  logic      r_s1_valid;
  codeword_t r_s1_code;
  logic      r_s2_valid;
  data_t     r_s2_sum_lo;
  data_t     r_s2_sum_hi;
  logic      r_s3_valid;
  data_t     r_s3_data;

  logic      w_s1_load;
  logic      w_s2_load;
  logic      w_s3_load;
  data_t     w_s2_sum_lo;
  data_t     w_s2_sum_hi;
  data_t     w_s3_sum;

  // Ready chain: a stage accepts when it is empty or its successor is accepting,
  // so a full pipeline advances in lock-step with out_ready.
  assign w_s3_load = out_ready | ~r_s3_valid;
  assign w_s2_load = w_s3_load | ~r_s2_valid;
  assign w_s1_load = w_s2_load | ~r_s1_valid;
  assign in_ready  = w_s1_load;

  assign w_s2_sum_lo = fib_sum(r_s1_code, 0, LO_LAST);
  assign w_s2_sum_hi = fib_sum(r_s1_code, LO_LAST + 1, TSV_W - 1);
  assign w_s3_sum    = r_s2_sum_lo + r_s2_sum_hi;

  // S1: capture the raw codeword.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code <= tsv_in;
      end
    end
  end

  // S2: register the two partial sums.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_sum_lo <= '0;
      r_s2_sum_hi <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum_lo <= w_s2_sum_lo;
        r_s2_sum_hi <= w_s2_sum_hi;
      end
    end
  end

  // S3: output register; only loads on a transfer or when empty, so data holds under backpressure.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_data  <= '0;
    end else if (w_s3_load) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_data <= w_s3_sum;
      end
    end
  end

  assign out_valid = r_s3_valid;
  assign dataout   = r_s3_data;

`ifdef FTF_RX_CHECK_EN
  logic             w_s1_forbidden;
  logic             w_s3_out_of_range;
  logic             w_err_xfer;
  logic             r_s2_pat;
  logic             r_s3_pat;
  logic             r_s3_rng;
  logic [CNT_W-1:0] r_err_cnt;

  ftf_pattern_check_23 u_pattern_check (
    .i_code      (r_s1_code),
    .o_forbidden (w_s1_forbidden)
  );

  assign w_s3_out_of_range = (w_s3_sum >= data_t'(CODE_LIMIT));
  assign w_err_xfer        = r_s3_valid & out_ready & (r_s3_pat | r_s3_rng);

  // S2 pattern flag travels alongside the partial sums.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_pat <= 1'b0;
    end else if (w_s2_load && r_s1_valid) begin
      r_s2_pat <= w_s1_forbidden;
    end
  end

  // S3 flags load together with the output word.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_pat <= 1'b0;
      r_s3_rng <= 1'b0;
    end else if (w_s3_load && r_s2_valid) begin
      r_s3_pat <= r_s2_pat;
      r_s3_rng <= w_s3_out_of_range;
    end
  end

  // Saturating count of erroneous words delivered; clear wins over an increment.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clear) begin
      r_err_cnt <= '0;
    end else if (w_err_xfer && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_pattern = r_s3_pat;
  assign err_range   = r_s3_rng;
  assign err_count   = r_err_cnt;
`else
  logic w_unused_clear;

  assign w_unused_clear = err_clear;
  assign err_pattern    = 1'b0;
  assign err_range      = 1'b0;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_ftf_rx_decoder_23.sv
// Self-checking bench for ftf_rx_decoder_23: scoreboard queue filled on accepted
// input, drained by a negedge monitor that compares against a reference model
// computed from Fibonacci arithmetic and the pattern rule.
module tb_ftf_rx_decoder_23;

`ifdef FTF_RX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [22:0]       tsv_in;
  logic              in_valid;
  logic              in_ready;
  logic [16:0]       dataout;
  logic              out_valid;
  logic              out_ready;
  logic              err_pattern;
  logic              err_range;
  logic [CNT_W-1:0]  err_count;
  logic              err_clear;

  ftf_rx_decoder_23 #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .tsv_in      (tsv_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dataout     (dataout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_pattern (err_pattern),
    .err_range   (err_range),
    .err_count   (err_count),
    .err_clear   (err_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [16:0] data;
    logic        pat;
    logic        rng;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  bit   strict_lat = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decode by Fibonacci weights generated on the fly, pattern rule evaluated pairwise.
  function automatic exp_t model(input logic [22:0] w, input int c);
    exp_t r;
    int unsigned prev, cur, nxt, sum;
    bit pat;
    prev = 1; cur = 1; sum = 0; pat = 1'b0;
    for (int k = 0; k < 23; k++) begin
      if (w[k]) sum = sum + cur;
      nxt = prev + cur;
      prev = cur;
      cur = nxt;
    end
    for (int j = 0; j < 22; j++) begin
      if ((j % 2) == 1 && w[j] && !w[j+1]) pat = 1'b1;
      if ((j % 2) == 0 && !w[j] && w[j+1]) pat = 1'b1;
    end
    r.data = 17'(sum);
    r.pat  = CHK && pat;
    r.rng  = CHK && (sum >= 75025);
    r.acc  = c;
    r.seen = 1'b0;
    return r;
  endfunction

  function automatic logic [22:0] legal_word();
    logic [22:0] w;
    w = '0;
    w[0] = 1'($urandom);
    for (int j = 0; j < 22; j++) begin
      if ((j % 2) == 0 && !w[j]) w[j+1] = 1'b0;
      else if ((j % 2) == 1 && w[j]) w[j+1] = 1'b1;
      else w[j+1] = 1'($urandom);
    end
    return w;
  endfunction

  // Monitor: push accepted words, compare presented outputs, track the error count.
  always @(negedge clock) begin
    exp_t e;
    bit   xfer_err;
    int   lat;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      chk("err_count", 32'(err_count), 32'(exp_cnt));
      xfer_err = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb[0];
          chk("dataout", 32'(dataout), 32'(e.data));
          chk("err_pattern", 32'(err_pattern), 32'(e.pat));
          chk("err_range", 32'(err_range), 32'(e.rng));
          if (!e.seen) begin
            lat = cyc - e.acc;
            if (strict_lat) chk("latency", 32'(lat), 32'd3);
            else            chk("latency_min", 32'(lat >= 3), 32'd1);
            sb[0].seen = 1'b1;
          end
          xfer_err = out_ready && (e.pat || e.rng);
        end
      end
      if (CHK) begin
        if (err_clear) exp_cnt = 0;
        else if (xfer_err && exp_cnt != MAXC) exp_cnt++;
      end
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) sb.push_back(model(tsv_in, cyc));
    end
  end

  task automatic send(input logic [22:0] w);
    int n;
    n = 0;
    tsv_in   = w;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 40) begin
      @(posedge clock); #2;
      n++;
    end
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; tsv_in = '0; out_ready = 1'b1; err_clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dataout", 32'(dataout), 32'd0);
    chk("rst_err_pattern", 32'(err_pattern), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // Directed words, back-to-back with out_ready held high.
    send(23'h000001); send(23'h000004); send(23'h000005);
    drain();
    send(23'h000002);
    drain();
    send(23'h7FFFFF);
    drain();

    // Saturate the counter with a stream of pattern errors.
    for (int i = 0; i < MAXC + 8; i++) send(23'h000002);
    drain();
    chk("sat_hold", 32'(err_count), CHK ? 32'(MAXC) : 32'd0);

    // Clear coinciding with an erroneous transfer.
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin
        err_clear = 1'b1;
        chk("clear_coincides_xfer", 32'(out_valid & out_ready), 32'd1);
      end
      send(23'h000002);
      err_clear = 1'b0;
    end
    drain();

    // Backpressure: three words fill the pipeline, the fourth stalls.
    strict_lat = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(legal_word());
    tsv_in = legal_word();
    in_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send(tsv_in);
    send(legal_word());
    drain();

    // Randomised traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      tsv_in    = ($urandom_range(0, 1) == 1) ? legal_word() : 23'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      err_clear = ($urandom_range(0, 19) == 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; err_clear = 1'b0;
    drain();

    // Asynchronous reset with a full pipeline and a nonzero error count.
    for (int i = 0; i < 3; i++) send(23'h000002);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(legal_word());
    @(posedge clock); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_dataout", 32'(dataout), 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    send(legal_word());
    send(23'h7FFFFF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
